mem_bus_ctrl: RTL and testbench
===============================

MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 750, meaning the number of 32-bit words in the attached data BRAM.
REQ-002 SHALL have parameter AW, default 12, meaning the width of the BRAM word address.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset that is synchronous and active-low.
REQ-005 SHALL have port req, input, 1, processor access request, sampled only in IDLE.
REQ-006 SHALL have port we, input, 1: 1 means store, 0 means load.
REQ-007 SHALL have port size, input, 2: 00 means byte, 01 means halfword, 10 means word, 11 means illegal.
REQ-008 SHALL have port sign, input, 1: 1 means sign-extend sub-word loads, 0 means zero-extend.
REQ-009 SHALL have port addr, input, 32, processor byte address.
REQ-010 SHALL have port wdata, input, 32, store data, right-justified.
REQ-011 SHALL have port rdata, output, 32, load result, right-justified and extended.
REQ-012 SHALL have port done, output, 1, a one-cycle completion pulse.
REQ-013 SHALL have port err, output, 1, an error flag valid only with done.
REQ-014 SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-015 SHALL have port mem_en, output, 1, BRAM enable.
REQ-016 SHALL have port mem_wen, output, 1, BRAM write enable.
REQ-017 SHALL have port mem_addr, output, AW, BRAM word address.
REQ-018 SHALL have port mem_wr_data, output, 32, BRAM write word.
REQ-019 SHALL have port mem_rd, input, 32, BRAM read word, valid at the rising edge after mem_addr has been held for one full cycle.

Function
REQ-020 SHALL implement the FSM states IDLE, RD, WR and RESP.
REQ-021 SHALL, in IDLE with req=1, register we, size, sign, addr and wdata, and SHALL ignore req in every other state.
REQ-022 SHALL treat an access as erroneous if any of the following holds: size=11; size=01 with addr[0]=1; size=10 with addr[1:0]!=00; word index addr[AW+1:2] >= DEPTH.
REQ-023 SHALL take an erroneous access IDLE->RESP with err=1, no BRAM write, and rdata unchanged.
REQ-024 SHALL take a load IDLE->RD->RESP; done rises 2 cycles after acceptance, and rdata is updated at the same edge from mem_rd.
REQ-025 SHALL take a word store IDLE->WR->RESP, driving mem_wen=1 and mem_wr_data=wdata for one cycle.
REQ-026 SHALL take a byte or halfword store IDLE->RD->WR->RESP: read-modify-write replacing only the addressed lanes of the captured mem_rd and preserving all other lanes.
REQ-027 SHALL use little-endian lanes: byte lane k = bits [8k+7:8k] with k = addr[1:0]; halfword lane = addr[1].
REQ-028 SHALL extend loaded bytes and halfwords to 32 bits according to sign (sign=1 replicates the MSB, sign=0 zero-fills).
REQ-029 SHALL drive mem_addr = latched addr[AW+1:2] in RD and WR, and 0 otherwise; addr bits above AW+1 are ignored before the DEPTH check.
REQ-030 SHALL assert mem_en in RD and WR only.
REQ-031 SHALL assert mem_wen only in WR and only while rst=1.
REQ-032 SHALL go RESP->IDLE unconditionally; done=1 only in RESP, so a new req can be accepted in the cycle after done.
REQ-033 SHALL hold rdata and err until the next done.
REQ-034 SHALL keep done a single-cycle pulse; back-to-back requests yield no gap between busy periods except the IDLE acceptance cycle.

Reset
REQ-035 SHALL, when rst=0 at a rising edge, force state=IDLE, rdata=0, done=0, err=0, busy=0, mem_en=0, mem_wen=0, mem_addr=0, mem_wr_data=0.
REQ-036 SHALL abort any access in progress when reset is asserted mid-operation, with no BRAM write and no done pulse for it.

Verification
REQ-037 SHALL cover a word store then load: sw 0xDEADBEEF @0x10, then lw @0x10 -> one mem_wen pulse with mem_addr=4; load done 2 cycles after acceptance with rdata=0xDEADBEEF.
REQ-038 SHALL cover a byte read-modify-write: word 0x11223344 @0x20, sb 0xAA @0x22 -> word becomes 0x11AA3344; then lb @0x22 -> rdata=0xFFFFFFAA, and lbu @0x22 -> rdata=0x000000AA.
REQ-039 SHALL cover a halfword load: lh @0x22 after the above -> rdata=0x000011AA.
REQ-040 SHALL cover misalignment: sh @0x21, and lw @0x12 -> done with err=1 one cycle after acceptance, mem_en never high, memory unchanged.
REQ-041 SHALL cover the bound: lw at word index 749 -> ok; lw at word index 750 (addr 0xBB8) -> err=1.
REQ-042 SHALL cover reset mid-operation: rst=0 during WR of an sb -> no write, state IDLE, all outputs 0; the next lw returns the old data.

Source files
------------

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: bridges a processor load/store request onto a single-port
// 32-bit data BRAM. Sub-word stores are done as read-modify-write, sub-word
// loads are lane-selected and sign/zero extended. Illegal or out-of-range
// accesses complete immediately with err set and never touch the BRAM.
module mem_bus_ctrl #(
    parameter int DEPTH = 750,
    parameter int AW    = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic          we,
    input  logic [1:0]    size,
    input  logic          sign,
    input  logic [31:0]   addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata,
    output logic          done,
    output logic          err,
    output logic          busy,
    output logic          mem_en,
    output logic          mem_wen,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wr_data,
    input  logic [31:0]   mem_rd
);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            we_q, we_d;
    logic [1:0]      size_q, size_d;
    logic            sign_q, sign_d;
    logic [1:0]      lane_q, lane_d;
    logic [AW-1:0]   widx_q, widx_d;
    logic [31:0]     wword_q, wword_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q, err_d;

    logic [31:0]     req_widx;
    logic            acc_err;
    logic            unused_addr_hi;

    // Replace only the addressed lanes of the old word with the store data.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                                input logic [31:0] wd,
                                                input logic [1:0]  sz,
                                                input logic [1:0]  lane);
        logic [31:0] res;
        res = old_w;
        case (sz)
            SZ_BYTE: res[{lane, 3'b000} +: 8] = wd[7:0];
            SZ_HALF: begin
                if (lane[1]) res[31:16] = wd[15:0];
                else         res[15:0]  = wd[15:0];
            end
            default: res = wd;
        endcase
        return res;
    endfunction

    // Select the addressed lanes of a read word and extend them to 32 bits.
    function automatic logic [31:0] extract_lanes(input logic [31:0] rd_w,
                                                  input logic [1:0]  sz,
                                                  input logic        sgn,
                                                  input logic [1:0]  lane);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = rd_w[{lane, 3'b000} +: 8];
        h = lane[1] ? rd_w[31:16] : rd_w[15:0];
        case (sz)
            SZ_BYTE: res = sgn ? {{24{b[7]}}, b} : {24'h0, b};
            SZ_HALF: res = sgn ? {{16{h[15]}}, h} : {16'h0, h};
            default: res = rd_w;
        endcase
        return res;
    endfunction

    // Address bits above the BRAM word index are deliberately ignored.
    assign unused_addr_hi = &{1'b0, addr[31:AW+2]};

    // Classify the incoming request: illegal size, misalignment or out of range.
    always_comb begin
        req_widx = 32'(addr[AW+1:2]);
        acc_err  = 1'b0;
        if (size == SZ_ILL)                          acc_err = 1'b1;
        if (size == SZ_HALF && addr[0])              acc_err = 1'b1;
        if (size == SZ_WORD && addr[1:0] != 2'b00)   acc_err = 1'b1;
        if (req_widx >= DEPTH_W)                     acc_err = 1'b1;
    end

    // Next-state logic plus capture of request fields and results.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        sign_d  = sign_q;
        lane_d  = lane_q;
        widx_d  = widx_q;
        wword_d = wword_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    we_d    = we;
                    size_d  = size;
                    sign_d  = sign;
                    lane_d  = addr[1:0];
                    widx_d  = addr[AW+1:2];
                    wword_d = wdata;
                    if (acc_err) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else if (we && size == SZ_WORD) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: begin
                if (we_q) begin
                    // Sub-word store: fold the new lanes into the word just read.
                    wword_d = merge_lanes(mem_rd, wword_q, size_q, lane_q);
                    state_d = WR;
                end else begin
                    rdata_d = extract_lanes(mem_rd, size_q, sign_q, lane_q);
                    err_d   = 1'b0;
                    state_d = RESP;
                end
            end
            WR: begin
                err_d   = 1'b0;
                state_d = RESP;
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control state and result registers; reset aborts any access in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Request fields are only consumed outside IDLE, so they need no reset.
    always_ff @(posedge clk) begin
        we_q    <= we_d;
        size_q  <= size_d;
        sign_q  <= sign_d;
        lane_q  <= lane_d;
        widx_q  <= widx_d;
        wword_q <= wword_d;
    end

    // Bus outputs decode directly from the state; write enable is masked by reset.
    always_comb begin
        busy        = (state_q != IDLE);
        done        = (state_q == RESP);
        mem_en      = (state_q == RD) || (state_q == WR);
        mem_wen     = (state_q == WR) && rst;
        mem_addr    = mem_en ? widx_q : '0;
        mem_wr_data = (state_q == WR) ? wword_q : 32'h0;
        rdata       = rdata_q;
        err         = err_q;
    end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl with a behavioural BRAM model
// (combinational read, write on rising edge when mem_en && mem_wen).
module tb_mem_bus_ctrl;

    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          req;
    logic          we;
    logic [1:0]    size;
    logic          sign;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic          done;
    logic          err;
    logic          busy;
    logic          mem_en;
    logic          mem_wen;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wr_data;
    logic [31:0]   mem_rd;

    logic [31:0]   mem [0:4095];
    int            wr_cnt = 0;
    int            en_cnt = 0;
    logic [AW-1:0] last_waddr = '0;

    int n_cmp = 0;
    int n_bad = 0;

    mem_bus_ctrl #(.DEPTH(750), .AW(AW)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .sign(sign),
        .addr(addr), .wdata(wdata), .rdata(rdata), .done(done), .err(err),
        .busy(busy), .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    assign mem_rd = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_en) en_cnt++;
        if (mem_en && mem_wen) begin
            mem[mem_addr] <= mem_wr_data;
            last_waddr    <= mem_addr;
            wr_cnt++;
        end
    end

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sign;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        int          exp_lat;
        logic        chk_rd;
        logic [31:0] exp_rd;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_acc(input vec_t v, input string tag);
        int  w0, e0, lat;
        logic got;
        w0  = wr_cnt;
        e0  = en_cnt;
        lat = 0;
        got = 1'b0;
        @(negedge clk);
        req = 1'b1; we = v.we; size = v.size; sign = v.sign;
        addr = v.addr; wdata = v.wdata;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (i == 1) begin
                req = 1'b0;
                check({tag, "_busy"}, 32'(busy), 32'd1);
            end
            if (done) begin
                lat = i;
                got = 1'b1;
                break;
            end
        end
        check({tag, "_lat"}, 32'(lat), 32'(v.exp_lat));
        if (got) begin
            check({tag, "_err"}, 32'(err), 32'(v.exp_err));
            if (v.chk_rd) check({tag, "_rdata"}, rdata, v.exp_rd);
            @(posedge clk); #1;
            check({tag, "_pulse"}, {30'h0, done, busy}, 32'h0);
        end
        check({tag, "_wcnt"}, 32'(wr_cnt - w0), (v.we && !v.exp_err) ? 32'd1 : 32'd0);
        if (v.exp_err) check({tag, "_encnt"}, 32'(en_cnt - e0), 32'd0);
        if (v.we && !v.exp_err) check({tag, "_waddr"}, 32'(last_waddr), 32'(v.addr[AW+1:2]));
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        mem[749] = 32'hCAFEF00D;

        //           we    sz     sgn   addr          wdata         err   lat chk   exp_rd
        vecs[0]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEADBEEF, 1'b0, 2, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,        1'b0, 2, 1'b1, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0020, 32'h11223344, 1'b0, 2, 1'b0, 32'h0};
        vecs[3]  = '{1'b1, 2'b00, 1'b0, 32'h0000_0022, 32'h123456AA, 1'b0, 3, 1'b0, 32'h0};
        vecs[4]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0,        1'b0, 2, 1'b1, 32'h11AA3344};
        vecs[5]  = '{1'b0, 2'b00, 1'b1, 32'h0000_0022, 32'h0,        1'b0, 2, 1'b1, 32'hFFFFFFAA};
        vecs[6]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0022, 32'h0,        1'b0, 2, 1'b1, 32'h000000AA};
        vecs[7]  = '{1'b0, 2'b01, 1'b1, 32'h0000_0022, 32'h0,        1'b0, 2, 1'b1, 32'h000011AA};
        vecs[8]  = '{1'b1, 2'b01, 1'b0, 32'h0000_0021, 32'h0000FFFF, 1'b1, 1, 1'b1, 32'h000011AA};
        vecs[9]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0012, 32'h0,        1'b1, 1, 1'b1, 32'h000011AA};
        vecs[10] = '{1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0,        1'b0, 2, 1'b1, 32'h11AA3344};
        vecs[11] = '{1'b0, 2'b10, 1'b0, 32'h0000_0BB4, 32'h0,        1'b0, 2, 1'b1, 32'hCAFEF00D};
        vecs[12] = '{1'b0, 2'b10, 1'b0, 32'h0000_0BB8, 32'h0,        1'b1, 1, 1'b1, 32'hCAFEF00D};
        vecs[13] = '{1'b0, 2'b11, 1'b0, 32'h0000_0010, 32'h0,        1'b1, 1, 1'b1, 32'hCAFEF00D};
        vecs[14] = '{1'b1, 2'b01, 1'b0, 32'h0000_0020, 32'h9999BEEF, 1'b0, 3, 1'b0, 32'h0};
        vecs[15] = '{1'b0, 2'b01, 1'b1, 32'h0000_0020, 32'h0,        1'b0, 2, 1'b1, 32'hFFFFBEEF};
        vecs[16] = '{1'b0, 2'b01, 1'b0, 32'h0000_0022, 32'h0,        1'b0, 2, 1'b1, 32'h000011AA};
        vecs[17] = '{1'b0, 2'b00, 1'b1, 32'h0000_0023, 32'h0,        1'b0, 2, 1'b1, 32'h00000011};
        vecs[18] = '{1'b1, 2'b00, 1'b0, 32'h0000_0023, 32'h00000080, 1'b0, 3, 1'b0, 32'h0};
        vecs[19] = '{1'b0, 2'b00, 1'b1, 32'h0000_0023, 32'h0,        1'b0, 2, 1'b1, 32'hFFFFFF80};
        vecs[20] = '{1'b0, 2'b10, 1'b0, 32'h8000_0010, 32'h0,        1'b0, 2, 1'b1, 32'hDEADBEEF};

        rst = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; sign = 1'b0;
        addr = 32'h0; wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl", {26'h0, done, err, busy, mem_en, mem_wen, 1'b0}, 32'h0);
        check("reset_rdata", rdata, 32'h0);
        check("reset_maddr", 32'(mem_addr), 32'h0);
        check("reset_wrdata", mem_wr_data, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < NV; i++) do_acc(vecs[i], $sformatf("v%0d", i));

        check("mem_w4", mem[4], 32'hDEADBEEF);
        check("mem_w8", mem[8], 32'h80AABEEF);

        // Reset asserted while a byte store sits in WR: write must be suppressed.
        begin
            int w0;
            logic saw_done;
            w0 = wr_cnt;
            saw_done = 1'b0;
            @(negedge clk);
            req = 1'b1; we = 1'b1; size = 2'b00; sign = 1'b0;
            addr = 32'h0000_0020; wdata = 32'h00000055;
            @(posedge clk); #1;
            req = 1'b0;
            if (done) saw_done = 1'b1;
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
            check("rmo_wen_before", {30'h0, mem_wen, busy}, 32'h3);
            rst = 1'b0;
            #1;
            check("rmo_wen_masked", 32'(mem_wen), 32'h0);
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
            check("rmo_outs", {26'h0, done, err, busy, mem_en, mem_wen, 1'b0}, 32'h0);
            check("rmo_rdata", rdata, 32'h0);
            check("rmo_maddr_wd", {20'h0, mem_addr} | mem_wr_data, 32'h0);
            check("rmo_nodone", 32'(saw_done), 32'h0);
            check("rmo_wcnt", 32'(wr_cnt - w0), 32'h0);
            check("rmo_mem", mem[8], 32'h80AABEEF);
            @(negedge clk);
            rst = 1'b1;
        end

        do_acc('{1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0, 1'b0, 2, 1'b1, 32'h80AABEEF}, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
